// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I controllers: FSM states, opcodes,
// ALU operation classes and datapath mux select values.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder shared by the single- and multicycle controllers:
// maps the coarse ALU operation class plus instruction fields to ALUControl.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_b5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Select the ALU function; only the funct class looks at funct3/funct7.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) may subtract; addi ignores Instr[30].
                    3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing the shared datapath,
// plus immediate-format and ALU-function decode.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       InstrDone,
    output logic       IllegalInstr,
    output logic [3:0] dbg_state
);

    if (XLEN != 32) begin : g_xlen_check
        $error("multicycle_controller supports RV32 only");
    end

    state_t     state_q, state_d;
    logic       pc_update, branch, mem_write_s, ir_write_s, reg_write_s;
    logic       instr_done_s, illegal_s;
    logic [1:0] alu_op;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and Moore outputs; unencoded states fall back to FETCH.
    always_comb begin
        state_d      = S_FETCH;
        pc_update    = 1'b0;
        branch       = 1'b0;
        AdrSrc       = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RD2;
        alu_op       = ALUOP_ADD;
        instr_done_s = 1'b0;
        illegal_s    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                pc_update  = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d      = S_FETCH;
                        illegal_s    = 1'b1;
                        instr_done_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = RES_DATA;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA      = SRCA_RD1;
                alu_op       = ALUOP_SUB;
                branch       = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_JAL: begin
                // PC takes the jump target from ALUOut; ALU forms OldPC+4 as link.
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Immediate format depends on the opcode alone.
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_b5       (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

    // Enables are masked while reset is high so nothing is written during reset.
    assign PCWrite      = ~reset & (pc_update | (branch & Zero));
    assign MemWrite     = ~reset & mem_write_s;
    assign IRWrite      = ~reset & ir_write_s;
    assign RegWrite     = ~reset & reg_write_s;
    assign InstrDone    = ~reset & instr_done_s;
    assign IllegalInstr = ~reset & illegal_s;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle vectors for multicycle_controller; a driver queues the
// expected output word for each cycle and a negedge monitor checks it.
module tb_multicycle_controller;
    import riscv_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] dbg_state;

    logic [21:0] exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [21:0] act;

    multicycle_controller #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .RegWrite(RegWrite), .InstrDone(InstrDone), .IllegalInstr(IllegalInstr),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    assign act = {dbg_state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite, InstrDone, IllegalInstr};

    // Expected output word: {state, pcw, adr, memw, irw, rs, srca, srcb, imm, aluc, regw, done, ill}
    function automatic logic [21:0] ev(input state_t s, input logic pcw, input logic adr,
                                       input logic memw, input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [2:0] aluc,
                                       input logic regw, input logic done, input logic ill);
        return {s, pcw, adr, memw, irw, rs, sa, sb, imm, aluc, regw, done, ill};
    endfunction

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [21:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (act !== e) begin
                n_err++;
                $display("FAIL %s: got %b required %b", nm, act, e);
            end
        end
    end

    // Driver: apply one cycle of inputs and queue what the DUT must show.
    task automatic step(input string nm, input logic r, input logic [6:0] o,
                        input logic [2:0] f3, input logic f7, input logic z,
                        input logic [21:0] e);
        reset    = r;
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic t_fetch(input string nm, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input logic [1:0] imm);
        step({nm, "_fetch"}, 1'b0, o, f3, f7, z,
             ev(S_FETCH, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0, 0));
    endtask

    task automatic t_decode(input string nm, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z, input logic [1:0] imm,
                            input logic ill);
        step({nm, "_decode"}, 1'b0, o, f3, f7, z,
             ev(S_DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, ill, ill));
    endtask

    // R-type: FETCH, DECODE, EXECUTER, ALUWB
    task automatic t_rtype(input string nm, input logic [2:0] f3, input logic f7,
                           input logic [2:0] aluc);
        t_fetch(nm, OP_R, f3, f7, 0, 2'b00);
        t_decode(nm, OP_R, f3, f7, 0, 2'b00, 0);
        step({nm, "_exec"}, 0, OP_R, f3, f7, 0,
             ev(S_EXECUTER, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, aluc, 0, 0, 0));
        step({nm, "_wb"}, 0, OP_R, f3, f7, 0,
             ev(S_ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0));
    endtask

    task automatic t_beq(input string nm, input logic z);
        t_fetch(nm, OP_BEQ, 3'b000, 0, z, 2'b10);
        t_decode(nm, OP_BEQ, 3'b000, 0, z, 2'b10, 0);
        step({nm, "_beq"}, 0, OP_BEQ, 3'b000, 0, z,
             ev(S_BEQ, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 1, 0));
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Held in reset: FETCH selects visible, every enable low.
        step("rst_hold0", 1, 7'd0, 3'd0, 0, 0,
             ev(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0));
        step("rst_hold1", 1, 7'd0, 3'd0, 0, 0,
             ev(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0));

        // lw: 5 cycles
        t_fetch("lw", OP_LW, 3'b010, 0, 0, 2'b00);
        t_decode("lw", OP_LW, 3'b010, 0, 0, 2'b00, 0);
        step("lw_memadr", 0, OP_LW, 3'b010, 0, 0,
             ev(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0));
        step("lw_memread", 0, OP_LW, 3'b010, 0, 0,
             ev(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0));
        step("lw_memwb", 0, OP_LW, 3'b010, 0, 0,
             ev(S_MEMWB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0));

        // sw: 4 cycles, S immediate
        t_fetch("sw", OP_SW, 3'b010, 0, 0, 2'b01);
        t_decode("sw", OP_SW, 3'b010, 0, 0, 2'b01, 0);
        step("sw_memadr", 0, OP_SW, 3'b010, 0, 0,
             ev(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0, 0, 0));
        step("sw_memwrite", 0, OP_SW, 3'b010, 0, 0,
             ev(S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 1, 0));

        // R-type ALU decode variants
        t_rtype("sub", 3'b000, 1, 3'b001);
        t_rtype("add", 3'b000, 0, 3'b000);
        t_rtype("slt", 3'b010, 0, 3'b101);
        t_rtype("or",  3'b110, 0, 3'b011);
        t_rtype("and", 3'b111, 0, 3'b010);

        // addi with Instr[30]=1 must still add
        t_fetch("addi", OP_I, 3'b000, 1, 0, 2'b00);
        t_decode("addi", OP_I, 3'b000, 1, 0, 2'b00, 0);
        step("addi_exec", 0, OP_I, 3'b000, 1, 0,
             ev(S_EXECUTEI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0));
        step("addi_wb", 0, OP_I, 3'b000, 1, 0,
             ev(S_ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0));

        // beq taken and not taken (Zero held across the whole instruction)
        t_beq("beq_taken", 1);
        t_beq("beq_not", 0);

        // jal
        t_fetch("jal", OP_JAL, 3'b000, 0, 0, 2'b11);
        t_decode("jal", OP_JAL, 3'b000, 0, 0, 2'b11, 0);
        step("jal_jal", 0, OP_JAL, 3'b000, 0, 0,
             ev(S_JAL, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0, 0));
        step("jal_wb", 0, OP_JAL, 3'b000, 0, 0,
             ev(S_ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1, 1, 0));

        // Illegal opcode: 2 cycles, pulse in DECODE, back to FETCH
        t_fetch("ill", 7'b1111111, 3'b000, 0, 0, 2'b00);
        t_decode("ill", 7'b1111111, 3'b000, 0, 0, 2'b00, 1);
        t_fetch("after_ill", 7'b1111111, 3'b000, 0, 0, 2'b00);
        t_decode("after_ill", OP_LW, 3'b010, 0, 0, 2'b00, 0);

        // Reset raised during MEMREAD of a lw, then released
        step("rlw_memadr", 0, OP_LW, 3'b010, 0, 0,
             ev(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0));
        step("rlw_memread", 0, OP_LW, 3'b010, 0, 0,
             ev(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0));
        step("rlw_abort0", 1, OP_LW, 3'b010, 0, 1,
             ev(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0));
        step("rlw_abort1", 1, OP_LW, 3'b010, 0, 1,
             ev(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0, 0));
        t_fetch("post_rst", OP_LW, 3'b010, 0, 0, 2'b00);
        t_decode("post_rst", OP_LW, 3'b010, 0, 0, 2'b00, 0);

        // Let the monitor consume the last vector, then confirm nothing is left over.
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
